// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and main memory.
// master: arbiter view (drives done/rdata toward caches and mem_* toward memory).
// slave: environment view (caches and memory model), directions mirrored.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  // I-cache side
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [LINE_W-1:0] i_rdata;
  // D-cache side
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_done;
  logic [LINE_W-1:0] d_rdata;
  // memory side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_rdata;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: serialise I-cache refills and D-cache refills/write-backs onto one memory port.
// Latency: req seen in IDLE at t -> mem_req at t+1; mem_ack at a -> done at a+1.
// Backpressure: one transaction in flight; later requests wait in IDLE until the current one finishes.
// Ports: clk, rst (async active-low); bus (mem_arbiter_if.master) carrying the I/D cache
// req/done/data and the memory req/ack/data; err = sticky watchdog flag.
// Optional macro ARB_RR_EN: round-robin on contention (default: D-cache has fixed priority).
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_if.master    bus,
  output logic             err
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state, state_nxt;
  logic              gnt_d;      // 1 = current grant is the D-cache
  logic              last_d;     // last served requester, 1 = D
  logic              mask_vld;   // first IDLE cycle after RESP: mask last_d side
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  cnt;
  logic [LINE_W-1:0] i_rdata_q, d_rdata_q;

  logic req_i_eff, req_d_eff, pick_d, timeout, busy;

  // The masked side is always the one just served, which RESP has already
  // recorded in last_d.
  assign req_i_eff = bus.i_req && !(mask_vld && !last_d);
  assign req_d_eff = bus.d_req && !(mask_vld &&  last_d);

`ifdef ARB_RR_EN
  assign pick_d = req_d_eff && (!req_i_eff || !last_d);
`else
  assign pick_d = req_d_eff;
`endif

  assign busy    = (state == BUSY);
  assign timeout = busy && !bus.mem_ack && (cnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_i_eff || req_d_eff) state_nxt = BUSY;
      BUSY:    if (bus.mem_ack || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt_d     <= 1'b0;
      last_d    <= 1'b0;
      mask_vld  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state    <= state_nxt;
      mask_vld <= (state == RESP);
      case (state)
        IDLE: begin
          if (req_i_eff || req_d_eff) begin
            gnt_d     <= pick_d;
            lat_we    <= pick_d && bus.d_we;
            lat_addr  <= pick_d ? bus.d_addr : bus.i_addr;
            lat_wdata <= pick_d ? bus.d_wdata : '0;
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            if (!lat_we) begin
              if (gnt_d) d_rdata_q <= bus.mem_rdata;
              else       i_rdata_q <= bus.mem_rdata;
            end
          end else if (timeout) begin
            // Abandon the transaction: report it and hand back a zero line.
            err <= 1'b1;
            if (!lat_we) begin
              if (gnt_d) d_rdata_q <= '0;
              else       i_rdata_q <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          last_d <= gnt_d;
          cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

  // Memory outputs are gated by BUSY so they read 0 outside a transaction
  // and drop at once on reset.
  assign bus.mem_req   = busy;
  assign bus.mem_we    = busy && lat_we;
  assign bus.mem_addr  = busy ? lat_addr  : '0;
  assign bus.mem_wdata = busy ? lat_wdata : '0;

  assign bus.i_done  = (state == RESP) && !gnt_d;
  assign bus.d_done  = (state == RESP) &&  gnt_d;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus hand-written
// contention, late-ack, watchdog and mid-transaction reset sequences.
module tb_mem_arbiter;

  localparam logic [127:0] DA = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DW = 128'hAAAAAAAAAAAAAAAA5555555555555555;
  localparam logic [127:0] DC = 128'hCAFEF00DCAFEF00DCAFEF00DCAFEF00D;
  localparam logic [127:0] DB = 128'h11112222333344445555666677778888;
  localparam logic [127:0] DE = 128'hEEEE0000EEEE0000EEEE0000EEEE0000;
  localparam logic [127:0] DF = 128'hF00DF00DF00DF00DF00DF00DF00DF00D;
  localparam logic [127:0] DH = 128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F;
  localparam logic [127:0] DJ = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .LINE_W(128)) bus ();

  mem_arbiter #(.ADDR_W(32), .LINE_W(128), .TIMEOUT_CYC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  typedef struct {
    logic         is_d;
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    int           delay;   // BUSY cycles without ack before the ack cycle
    logic [127:0] mrdata;
    logic [127:0] exp_i;   // i_rdata expected at done
    logic [127:0] exp_d;   // d_rdata expected at done
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One transaction; the requester keeps req through the masked IDLE cycle.
  task automatic run_vec(input vec_t v, input logic exp_err);
    @(posedge clk); #1;
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = v.addr;
    end
    @(negedge clk);
    chk("idle_mem_req", {127'd0, bus.mem_req}, 128'd0);
    for (int k = 0; k <= v.delay; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        if (v.is_d) bus.d_addr = ~v.addr;
        else        bus.i_addr = ~v.addr;
      end
      if (k == v.delay) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = v.mrdata;
      end
      @(negedge clk);
      chk("busy_mem_req", {127'd0, bus.mem_req}, 128'd1);
      chk("busy_mem_we", {127'd0, bus.mem_we}, {127'd0, v.is_d & v.we});
      chk("busy_mem_addr", {96'd0, bus.mem_addr}, {96'd0, v.addr});
      if (v.is_d && v.we) chk("busy_mem_wdata", bus.mem_wdata, v.wdata);
      chk("busy_no_done", {126'd0, bus.i_done, bus.d_done}, 128'd0);
    end
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.mem_rdata = DJ;
    @(negedge clk);
    chk("resp_mem_req", {127'd0, bus.mem_req}, 128'd0);
    chk("resp_done", {126'd0, bus.i_done, bus.d_done}, {126'd0, ~v.is_d, v.is_d});
    chk("resp_i_rdata", bus.i_rdata, v.exp_i);
    chk("resp_d_rdata", bus.d_rdata, v.exp_d);
    chk("resp_err", {127'd0, err}, {127'd0, exp_err});
    @(posedge clk); #1;
    @(negedge clk);
    chk("mask_no_done", {126'd0, bus.i_done, bus.d_done}, 128'd0);
    @(posedge clk); #1;
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    chk("mask_no_regrant", {127'd0, bus.mem_req}, 128'd0);
  endtask

  // Both caches request together and hold req; memory acks in the first BUSY
  // cycle. order[k] = 1 when the k-th completion went to D.
  task automatic contend(input logic dwe, input int n, output logic [3:0] order);
    int got;
    got = 0;
    order = '0;
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_A000;
    bus.d_req = 1'b1; bus.d_we = dwe; bus.d_addr = 32'h0000_B000; bus.d_wdata = DW;
    bus.mem_rdata = DE;
    for (int c = 0; c < 40 && got < n; c++) begin
      @(negedge clk);
      if (bus.i_done || bus.d_done) begin
        order[got] = bus.d_done;
        got++;
      end
      @(posedge clk); #1;
      if (got == n) begin
        bus.i_req = 1'b0; bus.d_req = 1'b0;
      end
      bus.mem_ack = bus.mem_req;
    end
    bus.mem_ack = 1'b0;
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    chk("contend_count", 128'(got), 128'(n));
  endtask

  vec_t       tbl[5];
  vec_t       v;
  logic [3:0] order;
  logic       exp_first;

  initial begin
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;

    tbl[0] = '{1'b0, 1'b0, 32'h0000_1040, 128'd0, 3, DA, DA,  128'd0};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_2000, DW,     1, DJ, DA,  128'd0};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_3000, DW,     0, DC, DA,  DC};
    tbl[3] = '{1'b1, 1'b1, 32'h0000_5000, DB,     0, DJ, DA,  DC};
    tbl[4] = '{1'b0, 1'b0, 32'h0000_4000, 128'd0, 2, DB, DB,  DC};

    #3 rst = 1'b0;
    #1;
    chk("rst_mem_req", {127'd0, bus.mem_req}, 128'd0);
    chk("rst_mem_addr", {96'd0, bus.mem_addr}, 128'd0);
    chk("rst_done", {126'd0, bus.i_done, bus.d_done}, 128'd0);
    chk("rst_i_rdata", bus.i_rdata, 128'd0);
    chk("rst_d_rdata", bus.d_rdata, 128'd0);
    chk("rst_err", {127'd0, err}, 128'd0);
    @(posedge clk); #3 rst = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(tbl[i], 1'b0);

    // Contention with last grant = I: D, I, D, I in either arbitration mode.
    contend(1'b0, 4, order);
    chk("contend_order", {124'd0, order}, {124'd0, 4'b0101});
    @(negedge clk);
    chk("contend_i_rdata", bus.i_rdata, DE);
    chk("contend_d_rdata", bus.d_rdata, DE);
    @(posedge clk); #1;

    // Make D the last grant, then collide: fixed priority keeps D, round-robin picks I.
    v = '{1'b1, 1'b0, 32'h0000_7000, 128'd0, 0, DF, DE, DF};
    run_vec(v, 1'b0);
    contend(1'b1, 1, order);
`ifdef ARB_RR_EN
    exp_first = 1'b0;
`else
    exp_first = 1'b1;
`endif
    chk("policy_first", {127'd0, order[0]}, {127'd0, exp_first});
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Stray ack in IDLE is ignored.
    bus.mem_ack = 1'b1; bus.mem_rdata = DJ;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_done", {126'd0, bus.i_done, bus.d_done}, 128'd0);
    chk("late_ack_mem_req", {127'd0, bus.mem_req}, 128'd0);
    chk("late_ack_i_rdata", bus.i_rdata, DE);
    chk("late_ack_d_rdata", bus.d_rdata, DF);

    // Watchdog: 8 BUSY cycles without ack.
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_6000;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("tmo_busy_mem_req", {127'd0, bus.mem_req}, 128'd1);
      chk("tmo_busy_err", {127'd0, err}, 128'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("tmo_err", {127'd0, err}, 128'd1);
    chk("tmo_mem_req", {127'd0, bus.mem_req}, 128'd0);
    chk("tmo_done", {126'd0, bus.i_done, bus.d_done}, 128'd2);
    chk("tmo_i_rdata", bus.i_rdata, 128'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.i_req = 1'b0;

    // Normal operation after the watchdog fired; err stays set.
    v = '{1'b0, 1'b0, 32'h0000_8000, 128'd0, 1, DH, DH, DF};
    run_vec(v, 1'b1);

    // Asynchronous reset in the middle of BUSY.
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_C000;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_mem_req", {127'd0, bus.mem_req}, 128'd1);
    chk("pre_rst_err", {127'd0, err}, 128'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_mem_req", {127'd0, bus.mem_req}, 128'd0);
    chk("async_rst_done", {126'd0, bus.i_done, bus.d_done}, 128'd0);
    chk("async_rst_err", {127'd0, err}, 128'd0);
    chk("async_rst_i_rdata", bus.i_rdata, 128'd0);
    bus.d_req = 1'b0;
    @(posedge clk);
    @(posedge clk); #3 rst = 1'b1;

    v = '{1'b1, 1'b1, 32'h0000_9000, DB, 0, DJ, 128'd0, 128'd0};
    run_vec(v, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
